// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the single-transfer Wishbone command master.
package wb_cmd_master_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int CNT_W    = 16;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Turns one command into one Wishbone classic cycle and returns a response,
// abandoning the cycle with an error if the slave does not ack in time.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,

    output logic                busy_o,
    output wb_state_e           dbg_state_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e           state_q,     state_d;
    logic                cyc_q,       cyc_d;
    logic                we_q,        we_d;
    logic [WB_ADR_W-1:0] adr_q,       adr_d;
    logic [WB_DAT_W-1:0] wdat_q,      wdat_d;
    logic [WB_SEL_W-1:0] sel_q,       sel_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic                rsp_err_q,   rsp_err_d;

    // Both handshakes are strict valid/ready: a beat moves on a rising edge
    // where valid and ready are both high; a valid source holds its payload.
    // Ready is only offered in IDLE, so acceptance reduces to cmd_valid_i there.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    wdat_d  = cmd_we_i ? cmd_dat_i : '0;
                    sel_d   = cmd_sel_i;
                    cnt_d   = '0;
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (wbm_ack_i || (cnt_q == TIMEOUT_LAST)) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    wdat_d      = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Gating with the reset pin keeps ready low while reset is held and
    // lets it rise as soon as reset is released.
    assign cmd_ready_o = (state_q == S_IDLE) && wb_rst_ni;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = wdat_q;
    assign wbm_sel_o   = sel_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
